icache_rport_arbiter: RTL and testbench

Shares the two ICache read ports between the IFU demand-fetch path and the instruction prefetcher. Sits between `ifu`/prefetcher and the ICache. Owns at most one read transaction at a time, forwarding the winner's request with zero added latency. Holds the ICache request until it is acknowledged and routes the ack, valid and data back to the owner only. IFU has priority, with a starvation counter that guarantees the prefetcher forward progress.

---
 rtl/icache_rport_arbiter.sv | 214 +++++++++++++++++++++
 tb/tb_icache_rport_arbiter.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_rport_arbiter.sv
// ============================================================================
// Module   : icache_rport_arbiter
// Purpose  : IFU / prefetcher arbitration of the two ICache read ports.
//            Optional prefetch path enabled by `ICACHE_PREFETCH_ARB_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module icache_rport_arbiter #(
  parameter int ADDR_WIDTH       = 32,
  parameter int ICACHELINE_WIDTH = 128,
  parameter int STARVE_LIMIT     = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          backend_flush_i,
  input  logic [1:0]                    ifu_rreq_i,
  input  logic [1:0]                    ifu_uncached_i,
  input  logic [2*ADDR_WIDTH-1:0]       ifu_raddr_i,
  output logic [1:0]                    ifu_rreq_ack_o,
  output logic [1:0]                    ifu_rvalid_o,
  output logic [2*ICACHELINE_WIDTH-1:0] ifu_rdata_o,
  input  logic                          pf_rreq_i,
  input  logic [ADDR_WIDTH-1:0]         pf_raddr_i,
  output logic                          pf_rreq_ack_o,
  output logic                          pf_rvalid_o,
  output logic [ICACHELINE_WIDTH-1:0]   pf_rdata_o,
  output logic [1:0]                    icache_rreq_o,
  output logic [1:0]                    icache_rreq_uncached_o,
  output logic [2*ADDR_WIDTH-1:0]       icache_raddr_o,
  input  logic [1:0]                    icache_rreq_ack_i,
  input  logic [1:0]                    icache_rvalid_i,
  input  logic [2*ICACHELINE_WIDTH-1:0] icache_rdata_i,
  output logic                          busy_o
);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_REQ  = 2'd1;
  localparam logic [1:0] c_WAIT = 2'd2;

  logic [1:0]              state_q, state_d;
  logic                    owner_q, owner_d;
  logic [1:0]              mask_q, mask_d;
  logic [1:0]              ack_q, ack_d;
  logic [1:0]              val_q, val_d;
  logic [1:0]              unc_q, unc_d;
  logic [2*ADDR_WIDTH-1:0] addr_q, addr_d;

  logic                    w_pf_win;
  logic                    w_ifu_win;
  logic                    w_grant;
  logic                    w_active;
  logic                    w_owner;
  logic [1:0]              w_mask;
  logic [1:0]              w_unc;
  logic [1:0]              w_ack_prev;
  logic [1:0]              w_val_prev;
  logic [2*ADDR_WIDTH-1:0] w_addr;
  logic                    w_ack_all;
  logic                    w_val_all;
  logic                    w_abandon;
  logic                    w_to_ifu;
  logic                    w_to_pf;

`ifdef ICACHE_PREFETCH_ARB_EN
  localparam int              c_SW         = $clog2(STARVE_LIMIT + 1);
  localparam logic [c_SW-1:0] c_STARVE_MAX = c_SW'(STARVE_LIMIT);

  logic [c_SW-1:0] starve_q, starve_d;

  assign w_pf_win = pf_rreq_i && ((starve_q == c_STARVE_MAX) || !ifu_rreq_i[0]);

  always_comb begin
    starve_d = starve_q;
    if (backend_flush_i) begin
      starve_d = '0;
    end else if (w_grant) begin
      if (w_pf_win || !pf_rreq_i) begin
        starve_d = '0;
      end else if (starve_q != c_STARVE_MAX) begin
        starve_d = starve_q + c_SW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end
`else
  logic w_unused_pf;
  assign w_unused_pf = pf_rreq_i ^ (STARVE_LIMIT != 0);
  assign w_pf_win    = 1'b0;
`endif

  assign w_ifu_win = ifu_rreq_i[0] && !w_pf_win;
  assign w_grant   = rst && (state_q == c_IDLE) && (w_ifu_win || w_pf_win);
  assign w_active  = rst && ((state_q != c_IDLE) || w_grant);

  // In the grant cycle the transaction is seen through the live request;
  // afterwards through the latched copy.
  always_comb begin
    w_owner    = owner_q;
    w_mask     = mask_q;
    w_unc      = unc_q;
    w_addr     = addr_q;
    w_ack_prev = ack_q;
    w_val_prev = val_q;
    if (state_q == c_IDLE) begin
      w_owner    = w_pf_win;
      w_mask     = w_pf_win ? 2'b01 : {ifu_rreq_i[1], 1'b1};
      w_unc      = w_pf_win ? 2'b00 : (ifu_uncached_i & w_mask);
      w_addr     = w_pf_win ? {{ADDR_WIDTH{1'b0}}, pf_raddr_i} : ifu_raddr_i;
      w_ack_prev = 2'b00;
      w_val_prev = 2'b00;
    end
  end

  assign w_ack_all = (((w_ack_prev | icache_rreq_ack_i) & w_mask) == w_mask);
  assign w_val_all = (((w_val_prev | icache_rvalid_i) & w_mask) == w_mask);
  assign w_abandon = backend_flush_i && (state_q == c_REQ) && owner_q &&
                     (ack_q == 2'b00) && ((icache_rreq_ack_i & mask_q) == 2'b00);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= c_IDLE;
      owner_q <= 1'b0;
      mask_q  <= 2'b00;
      ack_q   <= 2'b00;
      val_q   <= 2'b00;
      unc_q   <= 2'b00;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      mask_q  <= mask_d;
      ack_q   <= ack_d;
      val_q   <= val_d;
      unc_q   <= unc_d;
      addr_q  <= addr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    mask_d  = mask_q;
    unc_d   = unc_q;
    addr_d  = addr_q;
    ack_d   = (ack_q | icache_rreq_ack_i) & w_mask;
    val_d   = (val_q | icache_rvalid_i) & w_mask;
    case (state_q)
      c_IDLE: begin
        ack_d = icache_rreq_ack_i & w_mask;
        val_d = icache_rvalid_i & w_mask;
        if (w_grant) begin
          owner_d = w_owner;
          mask_d  = w_mask;
          unc_d   = w_unc;
          addr_d  = w_addr;
          state_d = !w_ack_all ? c_REQ : (w_val_all ? c_IDLE : c_WAIT);
        end
      end
      c_REQ: begin
        if (w_abandon) begin
          state_d = c_IDLE;
        end else if (w_ack_all) begin
          state_d = w_val_all ? c_IDLE : c_WAIT;
        end
      end
      c_WAIT: begin
        if (w_val_all) begin
          state_d = c_IDLE;
        end
      end
      default: state_d = c_IDLE;
    endcase
    if (state_d == c_IDLE) begin
      ack_d = 2'b00;
      val_d = 2'b00;
    end
  end

  assign w_to_ifu = w_active && !w_owner;
  assign w_to_pf  = w_active && w_owner;

  always_comb begin
    icache_rreq_o          = (w_active && !w_abandon) ? (w_mask & ~w_ack_prev) : 2'b00;
    icache_rreq_uncached_o = w_active ? w_unc : 2'b00;
    icache_raddr_o         = w_active ? w_addr : '0;
    ifu_rreq_ack_o         = w_to_ifu ? icache_rreq_ack_i : 2'b00;
    ifu_rvalid_o           = w_to_ifu ? icache_rvalid_i : 2'b00;
    ifu_rdata_o            = w_to_ifu ? icache_rdata_i : '0;
`ifdef ICACHE_PREFETCH_ARB_EN
    pf_rreq_ack_o          = w_to_pf && icache_rreq_ack_i[0];
    pf_rvalid_o            = w_to_pf && icache_rvalid_i[0];
    pf_rdata_o             = w_to_pf ? icache_rdata_i[ICACHELINE_WIDTH-1:0] : '0;
`else
    pf_rreq_ack_o          = 1'b0;
    pf_rvalid_o            = 1'b0;
    pf_rdata_o             = '0;
`endif
    busy_o                 = (state_q != c_IDLE);
  end

  logic w_unused_to_pf;
  assign w_unused_to_pf = w_to_pf;

endmodule

`default_nettype wire

// File: tb/tb_icache_rport_arbiter.sv
// ============================================================================
// Module   : tb_icache_rport_arbiter
// Purpose  : Directed scoreboard bench; prefetch cases follow
//            `ICACHE_PREFETCH_ARB_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_icache_rport_arbiter;

  localparam int AW = 32;
  localparam int DW = 128;

  logic            clk = 1'b0;
  logic            rst;
  logic            backend_flush_i;
  logic [1:0]      ifu_rreq_i;
  logic [1:0]      ifu_uncached_i;
  logic [2*AW-1:0] ifu_raddr_i;
  logic [1:0]      ifu_rreq_ack_o;
  logic [1:0]      ifu_rvalid_o;
  logic [2*DW-1:0] ifu_rdata_o;
  logic            pf_rreq_i;
  logic [AW-1:0]   pf_raddr_i;
  logic            pf_rreq_ack_o;
  logic            pf_rvalid_o;
  logic [DW-1:0]   pf_rdata_o;
  logic [1:0]      icache_rreq_o;
  logic [1:0]      icache_rreq_uncached_o;
  logic [2*AW-1:0] icache_raddr_o;
  logic [1:0]      icache_rreq_ack_i;
  logic [1:0]      icache_rvalid_i;
  logic [2*DW-1:0] icache_rdata_i;
  logic            busy_o;

  icache_rport_arbiter #(
    .ADDR_WIDTH      (AW),
    .ICACHELINE_WIDTH(DW),
    .STARVE_LIMIT    (4)
  ) dut (
    .clk                   (clk),
    .rst                   (rst),
    .backend_flush_i       (backend_flush_i),
    .ifu_rreq_i            (ifu_rreq_i),
    .ifu_uncached_i        (ifu_uncached_i),
    .ifu_raddr_i           (ifu_raddr_i),
    .ifu_rreq_ack_o        (ifu_rreq_ack_o),
    .ifu_rvalid_o          (ifu_rvalid_o),
    .ifu_rdata_o           (ifu_rdata_o),
    .pf_rreq_i             (pf_rreq_i),
    .pf_raddr_i            (pf_raddr_i),
    .pf_rreq_ack_o         (pf_rreq_ack_o),
    .pf_rvalid_o           (pf_rvalid_o),
    .pf_rdata_o            (pf_rdata_o),
    .icache_rreq_o         (icache_rreq_o),
    .icache_rreq_uncached_o(icache_rreq_uncached_o),
    .icache_raddr_o        (icache_raddr_o),
    .icache_rreq_ack_i     (icache_rreq_ack_i),
    .icache_rvalid_i       (icache_rvalid_i),
    .icache_rdata_i        (icache_rdata_i),
    .busy_o                (busy_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          pf;
    logic          port;
    logic [DW-1:0] data;
  } rsp_t;

  rsp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic check_rsp(input logic pf, input logic port, input logic [DW-1:0] data);
    rsp_t e;
    if (exp_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL unexpected_rvalid: got pf=%0d port=%0d data=%0h expected none (t=%0t)",
               pf, port, data, $time);
    end else begin
      e = exp_q.pop_front();
      chk("rsp_owner", {127'd0, pf}, {127'd0, e.pf});
      chk("rsp_port", {127'd0, port}, {127'd0, e.port});
      chk("rsp_data", data, e.data);
    end
  endtask

  // Response monitor: every routed valid must match the next scoreboard entry.
  always @(negedge clk) begin
    for (int p = 0; p < 2; p++) begin
      if (ifu_rvalid_o[p] === 1'b1) check_rsp(1'b0, p[0], ifu_rdata_o[p*DW +: DW]);
    end
    if (pf_rvalid_o === 1'b1) check_rsp(1'b1, 1'b0, pf_rdata_o);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "timeout");
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  // Drive an ICache valid on one port and record who should receive it.
  task automatic give_valid(input int port, input logic [DW-1:0] d, input logic to_pf);
    icache_rvalid_i[port]          = 1'b1;
    icache_rdata_i[port*DW +: DW]  = d;
    exp_q.push_back('{pf: to_pf, port: port[0], data: d});
  endtask

  localparam logic [AW-1:0] IFU_A = 32'h1C00_0040;
  localparam logic [AW-1:0] PF_A  = 32'h2000_0100;

  logic exp_pf [6];

  initial begin
    rst               = 1'b0;
    backend_flush_i   = 1'b0;
    ifu_rreq_i        = 2'b01;
    ifu_uncached_i    = 2'b00;
    ifu_raddr_i       = {32'h0, IFU_A};
    pf_rreq_i         = 1'b0;
    pf_raddr_i        = '0;
    icache_rreq_ack_i = 2'b11;
    icache_rvalid_i   = 2'b00;
    icache_rdata_i    = '0;
    for (int i = 0; i < 6; i++) begin
`ifdef ICACHE_PREFETCH_ARB_EN
      exp_pf[i] = (i == 4);
`else
      exp_pf[i] = 1'b0;
`endif
    end

    // Reset: request and ack present, everything gated off.
    mid();
    chk("rst_rreq", icache_rreq_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_ifu_ack", ifu_rreq_ack_o, 0);
    chk("rst_raddr", icache_raddr_o, 0);
    next_cycle();
    rst = 1'b1;
    ifu_rreq_i = 2'b00;
    icache_rreq_ack_i = 2'b00;
    next_cycle();

    // IFU single-port, same-cycle ack, valid three cycles later.
    ifu_rreq_i = 2'b01;
    icache_rreq_ack_i = 2'b01;
    mid();
    chk("s1_c0_rreq", icache_rreq_o, 2'b01);
    chk("s1_c0_raddr", icache_raddr_o[AW-1:0], IFU_A);
    chk("s1_c0_ifu_ack", ifu_rreq_ack_o, 2'b01);
    chk("s1_c0_pf_ack", pf_rreq_ack_o, 0);
    chk("s1_c0_busy", busy_o, 0);
    next_cycle();
    ifu_rreq_i = 2'b00;
    icache_rreq_ack_i = 2'b00;
    mid();
    chk("s1_c1_rreq", icache_rreq_o, 2'b00);
    chk("s1_c1_busy", busy_o, 1);
    next_cycle();
    mid();
    chk("s1_c2_busy", busy_o, 1);
    next_cycle();
    give_valid(0, 128'h1111_2222_3333_4444_5555_6666_7777_8888, 1'b0);
    mid();
    chk("s1_c3_busy", busy_o, 1);
    chk("s1_c3_pf_valid", pf_rvalid_o, 0);
    next_cycle();
    icache_rvalid_i = 2'b00;
    mid();
    chk("s1_c4_busy", busy_o, 0);
    chk("s1_c4_rreq", icache_rreq_o, 0);
    next_cycle();

    // IFU cross-line: staggered acks and valids on both ports.
    ifu_rreq_i = 2'b11;
    ifu_uncached_i = 2'b10;
    ifu_raddr_i = {32'h1C00_00D0, 32'h1C00_00C0};
    icache_rreq_ack_i = 2'b01;
    mid();
    chk("s2_c0_rreq", icache_rreq_o, 2'b11);
    chk("s2_c0_raddr", icache_raddr_o, {32'h1C00_00D0, 32'h1C00_00C0});
    chk("s2_c0_unc", icache_rreq_uncached_o, 2'b10);
    next_cycle();
    icache_rreq_ack_i = 2'b00;
    ifu_raddr_i = '0;
    mid();
    chk("s2_c1_rreq", icache_rreq_o, 2'b10);
    chk("s2_c1_raddr_latched", icache_raddr_o, {32'h1C00_00D0, 32'h1C00_00C0});
    chk("s2_c1_unc", icache_rreq_uncached_o, 2'b10);
    next_cycle();
    icache_rreq_ack_i = 2'b10;
    mid();
    chk("s2_c2_rreq", icache_rreq_o, 2'b10);
    chk("s2_c2_ifu_ack", ifu_rreq_ack_o, 2'b10);
    next_cycle();
    icache_rreq_ack_i = 2'b00;
    mid();
    chk("s2_c3_rreq", icache_rreq_o, 2'b00);
    chk("s2_c3_busy", busy_o, 1);
    next_cycle();
    give_valid(1, 128'hBEEF_0001, 1'b0);
    mid();
    chk("s2_c4_busy", busy_o, 1);
    chk("s2_c4_rreq", icache_rreq_o, 2'b00);
    next_cycle();
    icache_rvalid_i = 2'b00;
    ifu_rreq_i = 2'b00;
    give_valid(0, 128'hBEEF_0000, 1'b0);
    mid();
    chk("s2_c5_busy", busy_o, 1);
    next_cycle();
    icache_rvalid_i = 2'b00;
    ifu_uncached_i = 2'b00;
    mid();
    chk("s2_c6_busy", busy_o, 0);
    chk("s2_c6_rreq", icache_rreq_o, 2'b00);
    next_cycle();

    // Continuous IFU + PF requests: starvation counter forces one PF grant.
    ifu_rreq_i = 2'b01;
    ifu_uncached_i = 2'b01;
    ifu_raddr_i = {32'h0, IFU_A};
    pf_rreq_i = 1'b1;
    pf_raddr_i = PF_A;
    for (int i = 0; i < 6; i++) begin
      icache_rvalid_i = 2'b00;
      icache_rreq_ack_i = 2'b01;
      mid();
      chk("starve_rreq", icache_rreq_o, 2'b01);
      chk("starve_raddr", icache_raddr_o[AW-1:0], exp_pf[i] ? PF_A : IFU_A);
      chk("starve_unc", icache_rreq_uncached_o, exp_pf[i] ? 2'b00 : 2'b01);
      chk("starve_pf_ack", pf_rreq_ack_o, exp_pf[i]);
      chk("starve_ifu_ack", ifu_rreq_ack_o, exp_pf[i] ? 2'b00 : 2'b01);
      next_cycle();
      icache_rreq_ack_i = 2'b00;
      give_valid(0, 128'hA000 + i, exp_pf[i]);
      mid();
      chk("starve_busy_wait", busy_o, 1);
      next_cycle();
    end
    icache_rvalid_i = 2'b00;
    ifu_rreq_i = 2'b00;
    ifu_uncached_i = 2'b00;
    pf_rreq_i = 1'b0;
    mid();
    chk("starve_end_busy", busy_o, 0);
    next_cycle();

`ifdef ICACHE_PREFETCH_ARB_EN
    // PF granted, ack withheld, flush in cycle 2 abandons it.
    pf_rreq_i = 1'b1;
    mid();
    chk("fl_c0_rreq", icache_rreq_o, 2'b01);
    chk("fl_c0_raddr", icache_raddr_o[AW-1:0], PF_A);
    chk("fl_c0_pf_ack", pf_rreq_ack_o, 0);
    next_cycle();
    mid();
    chk("fl_c1_rreq", icache_rreq_o, 2'b01);
    chk("fl_c1_busy", busy_o, 1);
    next_cycle();
    backend_flush_i = 1'b1;
    mid();
    chk("fl_c2_rreq", icache_rreq_o, 2'b00);
    next_cycle();
    backend_flush_i = 1'b0;
    pf_rreq_i = 1'b0;
    mid();
    chk("fl_c3_busy", busy_o, 0);
    chk("fl_c3_pf_valid", pf_rvalid_o, 0);
    next_cycle();
`else
    // Prefetch path compiled out: a lone PF request is never granted.
    pf_rreq_i = 1'b1;
    icache_rreq_ack_i = 2'b01;
    mid();
    chk("nopf_rreq", icache_rreq_o, 2'b00);
    chk("nopf_pf_ack", pf_rreq_ack_o, 0);
    next_cycle();
    pf_rreq_i = 1'b0;
    icache_rreq_ack_i = 2'b00;
    mid();
    chk("nopf_busy", busy_o, 0);
    next_cycle();
`endif

    // Reset asserted while in WAIT.
    ifu_rreq_i = 2'b01;
    icache_rreq_ack_i = 2'b01;
    mid();
    chk("rw_c0_rreq", icache_rreq_o, 2'b01);
    next_cycle();
    icache_rreq_ack_i = 2'b00;
    mid();
    chk("rw_c1_busy", busy_o, 1);
    next_cycle();
    rst = 1'b0;
    icache_rvalid_i = 2'b01;
    icache_rdata_i[DW-1:0] = 128'hDEAD;
    #1;
    chk("rw_rst_busy", busy_o, 0);
    chk("rw_rst_rreq", icache_rreq_o, 0);
    chk("rw_rst_valid", ifu_rvalid_o, 0);
    chk("rw_rst_data", ifu_rdata_o[DW-1:0], 0);
    next_cycle();
    rst = 1'b1;
    icache_rvalid_i = 2'b00;
    icache_rreq_ack_i = 2'b01;
    ifu_raddr_i = {32'h0, 32'h1C00_0080};
    mid();
    chk("rw_new_rreq", icache_rreq_o, 2'b01);
    chk("rw_new_raddr", icache_raddr_o[AW-1:0], 32'h1C00_0080);
    chk("rw_new_ack", ifu_rreq_ack_o, 2'b01);
    next_cycle();
    ifu_rreq_i = 2'b00;
    icache_rreq_ack_i = 2'b00;
    give_valid(0, 128'hCAFE, 1'b0);
    mid();
    chk("rw_new_busy", busy_o, 1);
    next_cycle();
    icache_rvalid_i = 2'b00;
    mid();
    chk("rw_end_busy", busy_o, 0);
    next_cycle();

    mid();
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
